// File: rtl/pri_encoder_irq_pkg.sv
// Shared types and constants for the pri_encoder_irq interrupt/event grant block.
package pri_encoder_irq_pkg;

  typedef enum logic {
    ST_IDLE    = 1'b0,
    ST_PRESENT = 1'b1
  } st_e;

  localparam logic MODE_FIXED = 1'b0;
  localparam logic MODE_RR    = 1'b1;

endpackage

// File: rtl/pri_encoder_irq_enc.sv
// Combinational N-input priority encoder (pri_encoder_n).
// LSB_FIRST=0 picks the highest set index; LSB_FIRST=1 picks the lowest.
module pri_encoder_n
  import pri_encoder_irq_pkg::*;
#(
  parameter int N         = 8,
  parameter bit LSB_FIRST = 1'b0,
  localparam int W        = $clog2(N)
) (
  input  logic [N-1:0] i_vec,
  output logic [W-1:0] o_idx,
  output logic         o_none
);

  always_comb begin
    o_idx  = '0;
    o_none = ~|i_vec;
    // Later loop iterations overwrite earlier ones, so the scan direction sets priority.
    if (LSB_FIRST) begin
      for (int i = N - 1; i >= 0; i--) begin
        if (i_vec[i]) o_idx = W'(i);
      end
    end else begin
      for (int i = 0; i < N; i++) begin
        if (i_vec[i]) o_idx = W'(i);
      end
    end
  end

endmodule

// File: rtl/pri_encoder_irq.sv
// Registered N-channel priority encoder with edge/level request latching, masking,
// fixed or round-robin selection and a valid/ack grant handshake.
module pri_encoder_irq
  import pri_encoder_irq_pkg::*;
#(
  parameter int N    = 8,
  parameter bit EDGE = 1'b1,
  localparam int W   = $clog2(N)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] i_req,
  input  logic [N-1:0] i_mask,
  input  logic         i_rr,
  input  logic         i_ack,
  output logic [W-1:0] o_out,
  output logic         o_valid,
  output logic         o_dis,
  output logic [W:0]   o_pend_cnt,
  output st_e          o_state
);

  // Handshake: o_valid=1 presents o_out; a cycle with o_valid=1 and i_ack=1 is the
  // accepting transfer. o_out is never withdrawn or changed while o_valid=1.

  st_e          r_state, w_state_nxt;
  logic [N-1:0] r_req_q, r_pending, w_pend_nxt, w_elig, w_clr, w_rot;
  logic [W-1:0] r_ptr, w_ptr_nxt, w_fix_idx, w_rot_idx, w_rr_idx, w_out_nxt;
  logic [W:0]   w_rr_sum, w_cnt;
  logic         r_mode, w_mode_nxt, w_valid_nxt, w_ack_acc;
  logic         w_fix_none, w_rot_none;

  assign o_state   = r_state;
  assign w_ack_acc = (r_state == ST_PRESENT) && i_ack;
  assign w_elig    = r_pending & i_mask;
  assign w_clr     = w_ack_acc ? ({{(N-1){1'b0}}, 1'b1} << o_out) : '0;

  // Edge mode: a new rising edge beats the ack clear of the same bit.
  always_comb begin
    if (EDGE) w_pend_nxt = (r_pending & ~w_clr) | (i_req & ~r_req_q);
    else      w_pend_nxt = i_req;
  end

  always_comb begin
    w_cnt = '0;
    for (int i = 0; i < N; i++) w_cnt = w_cnt + {{W{1'b0}}, w_pend_nxt[i]};
  end

  // Rotate right by ptr so bit 0 of w_rot is channel ptr.
  always_comb begin
    w_rot = '0;
    for (int i = 0; i < N; i++) w_rot[i] = w_elig[(i + int'(r_ptr)) % N];
  end

  pri_encoder_n #(.N(N), .LSB_FIRST(1'b0)) u_fix (
    .i_vec  (w_elig),
    .o_idx  (w_fix_idx),
    .o_none (w_fix_none)
  );

  pri_encoder_n #(.N(N), .LSB_FIRST(1'b1)) u_rr (
    .i_vec  (w_rot),
    .o_idx  (w_rot_idx),
    .o_none (w_rot_none)
  );

  assign w_rr_sum = {1'b0, w_rot_idx} + {1'b0, r_ptr};
  assign w_rr_idx = W'((w_rr_sum >= (W+1)'(N)) ? (w_rr_sum - (W+1)'(N)) : w_rr_sum);

  always_comb begin
    w_state_nxt = r_state;
    w_out_nxt   = o_out;
    w_valid_nxt = o_valid;
    w_ptr_nxt   = r_ptr;
    w_mode_nxt  = r_mode;
    case (r_state)
      ST_IDLE: begin
        if (i_rr == MODE_RR ? !w_rot_none : !w_fix_none) begin
          w_out_nxt   = (i_rr == MODE_RR) ? w_rr_idx : w_fix_idx;
          w_mode_nxt  = i_rr;
          w_valid_nxt = 1'b1;
          w_state_nxt = ST_PRESENT;
        end
      end
      ST_PRESENT: begin
        if (i_ack) begin
          w_valid_nxt = 1'b0;
          w_state_nxt = ST_IDLE;
          if (r_mode == MODE_RR)
            w_ptr_nxt = (o_out == W'(N - 1)) ? '0 : o_out + W'(1);
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_req_q    <= '0;
      r_pending  <= '0;
      r_ptr      <= '0;
      r_mode     <= MODE_FIXED;
      o_out      <= '0;
      o_valid    <= 1'b0;
      o_dis      <= 1'b1;
      o_pend_cnt <= '0;
    end else begin
      r_req_q    <= i_req;
      r_pending  <= w_pend_nxt;
      r_ptr      <= w_ptr_nxt;
      r_mode     <= w_mode_nxt;
      o_out      <= w_out_nxt;
      o_valid    <= w_valid_nxt;
      o_dis      <= ~|(w_pend_nxt & i_mask);
      o_pend_cnt <= w_cnt;
    end
  end

endmodule

// File: tb/tb_pri_encoder_irq.sv
// Directed bench for pri_encoder_irq: edge-mode instance (a) and level-mode instance (b),
// grants checked against expected-index queues by per-instance monitors.
module tb_pri_encoder_irq;
  import pri_encoder_irq_pkg::*;

  localparam int N = 8;
  localparam int W = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b1;

  logic [N-1:0] req_a = '0, mask_a = 8'hFF;
  logic         rr_a = 1'b0, ack_a = 1'b0;
  logic [W-1:0] out_a;
  logic         valid_a, dis_a;
  logic [W:0]   cnt_a;
  st_e          st_a;

  logic [N-1:0] req_b = '0, mask_b = 8'hFF;
  logic         rr_b = 1'b0, ack_b = 1'b0;
  logic [W-1:0] out_b;
  logic         valid_b, dis_b;
  logic [W:0]   cnt_b;
  st_e          st_b;

  logic [W-1:0] exp_q[$];
  logic [W-1:0] exp_q_b[$];
  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  pri_encoder_irq #(.N(N), .EDGE(1'b1)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .i_req(req_a), .i_mask(mask_a), .i_rr(rr_a), .i_ack(ack_a),
    .o_out(out_a), .o_valid(valid_a), .o_dis(dis_a), .o_pend_cnt(cnt_a), .o_state(st_a)
  );

  pri_encoder_irq #(.N(N), .EDGE(1'b0)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .i_req(req_b), .i_mask(mask_b), .i_rr(rr_b), .i_ack(ack_b),
    .o_out(out_b), .o_valid(valid_b), .o_dis(dis_b), .o_pend_cnt(cnt_b), .o_state(st_b)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic wait_valid_a();
    int n = 0;
    while (!valid_a && n < 20) begin
      tick();
      n++;
    end
    if (!valid_a) begin
      n_vec++;
      n_err++;
      $display("FAIL timeout_a: valid got 0 expected 1 within 20 cycles");
    end
  endtask

  task automatic ack_a_once();
    wait_valid_a();
    ack_a = 1'b1;
    tick();
    ack_a = 1'b0;
  endtask

  // Monitor: a new grant is a rising valid seen at the falling clock edge.
  logic prev_a = 1'b0, prev_b = 1'b0;
  always @(negedge clk) begin
    if (valid_a && !prev_a) begin
      if (exp_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL grant_a: got out=%0d expected no grant", out_a);
      end else begin
        check("grant_a", 32'(out_a), 32'(exp_q.pop_front()));
      end
    end
    if (valid_b && !prev_b) begin
      if (exp_q_b.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL grant_b: got out=%0d expected no grant", out_b);
      end else begin
        check("grant_b", 32'(out_b), 32'(exp_q_b.pop_front()));
      end
    end
    prev_a = valid_a;
    prev_b = valid_b;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish before 200us");
    $fatal(1, "watchdog");
  end

  initial begin
    // Power-on reset
    #1 rst_n = 1'b0;
    #1;
    check("rst_out", 32'(out_a), 0);
    check("rst_valid", 32'(valid_a), 0);
    check("rst_dis", 32'(dis_a), 1);
    check("rst_cnt", 32'(cnt_a), 0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();

    // Fixed priority, two pending channels
    req_a = 8'h22;
    exp_q.push_back(3'd5);
    exp_q.push_back(3'd1);
    tick();
    check("fix_cnt2", 32'(cnt_a), 2);
    check("fix_lat_valid0", 32'(valid_a), 0);
    tick();
    check("fix_valid", 32'(valid_a), 1);
    check("fix_out5", 32'(out_a), 5);
    ack_a_once();
    check("fix_cnt1", 32'(cnt_a), 1);
    ack_a_once();
    check("fix_dis", 32'(dis_a), 1);
    check("fix_cnt0", 32'(cnt_a), 0);
    req_a = 8'h00;
    tick();

    // Masked channel stays pending but ungranted
    mask_a = 8'h7F;
    req_a  = 8'h80;
    tick();
    check("mask_valid0", 32'(valid_a), 0);
    check("mask_dis", 32'(dis_a), 1);
    check("mask_cnt1", 32'(cnt_a), 1);
    tick();
    check("mask_hold_valid0", 32'(valid_a), 0);
    check("mask_hold_cnt1", 32'(cnt_a), 1);
    mask_a = 8'hFF;
    exp_q.push_back(3'd7);
    tick();
    check("unmask_dis0", 32'(dis_a), 0);
    ack_a_once();
    req_a = 8'h00;
    tick();

    // Round robin over all channels, then pointer wrap
    rr_a  = 1'b1;
    req_a = 8'hFF;
    for (int i = 0; i < N; i++) exp_q.push_back(W'(i));
    tick();
    check("rr_cnt8", 32'(cnt_a), 8);
    for (int i = 0; i < N; i++) ack_a_once();
    check("rr_dis", 32'(dis_a), 1);
    check("rr_cnt0", 32'(cnt_a), 0);
    req_a = 8'h00;
    tick();
    req_a = 8'h21;
    exp_q.push_back(3'd0);
    exp_q.push_back(3'd5);
    tick();
    ack_a_once();
    ack_a_once();
    req_a = 8'h00;
    tick();
    req_a = 8'h82;
    exp_q.push_back(3'd7);
    exp_q.push_back(3'd1);
    tick();
    ack_a_once();
    ack_a_once();
    rr_a  = 1'b0;
    req_a = 8'h00;
    tick();

    // Ack collides with a new edge on the granted channel
    req_a = 8'h08;
    exp_q.push_back(3'd3);
    tick();
    req_a = 8'h00;
    wait_valid_a();
    ack_a = 1'b1;
    req_a = 8'h08;
    tick();
    ack_a = 1'b0;
    check("coll_valid0", 32'(valid_a), 0);
    check("coll_cnt1", 32'(cnt_a), 1);
    exp_q.push_back(3'd3);
    tick();
    check("coll_regrant_valid", 32'(valid_a), 1);
    check("coll_regrant_out", 32'(out_a), 3);
    ack_a = 1'b1;
    req_a = 8'h00;
    tick();
    ack_a = 1'b0;
    check("coll_dis", 32'(dis_a), 1);

    // Level mode: grant held after request drops
    req_b = 8'h04;
    exp_q_b.push_back(3'd2);
    tick();
    check("lvl_cnt1", 32'(cnt_b), 1);
    tick();
    check("lvl_valid", 32'(valid_b), 1);
    check("lvl_out2", 32'(out_b), 2);
    req_b = 8'h00;
    tick();
    tick();
    check("lvl_hold_valid", 32'(valid_b), 1);
    check("lvl_hold_out", 32'(out_b), 2);
    ack_b = 1'b1;
    tick();
    ack_b = 1'b0;
    check("lvl_ack_valid0", 32'(valid_b), 0);
    check("lvl_dis", 32'(dis_b), 1);
    tick();
    check("lvl_no_regrant", 32'(valid_b), 0);

    // Asynchronous reset in the middle of a presented grant
    req_a = 8'h10;
    exp_q.push_back(3'd4);
    tick();
    tick();
    check("mid_valid", 32'(valid_a), 1);
    @(negedge clk);
    #2;
    req_a = 8'h00;
    rst_n = 1'b0;
    #1;
    check("mid_rst_out", 32'(out_a), 0);
    check("mid_rst_valid", 32'(valid_a), 0);
    check("mid_rst_dis", 32'(dis_a), 1);
    check("mid_rst_cnt", 32'(cnt_a), 0);
    check("mid_rst_state", 32'(st_a), 32'(ST_IDLE));
    tick();
    rst_n = 1'b1;
    tick();
    tick();
    check("post_rst_valid0", 32'(valid_a), 0);
    check("post_rst_cnt0", 32'(cnt_a), 0);

    tick();
    check("exp_q_a_empty", 32'(exp_q.size()), 0);
    check("exp_q_b_empty", 32'(exp_q_b.size()), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
